// File: rtl/cpu_sram_responder_if.sv
// Bus bundle between the CPU/loader side and the SRAM responder.
// Carries both CPU SRAM ports, the loader handshake and the run/halt status.
interface cpu_sram_responder_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_we_n;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  ld_valid;
   logic                  ld_ready;
   logic                  ld_sel;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  ld_done;
   logic                  cpu_run;
   logic                  halted;
   logic [DATA_WIDTH-1:0] halt_code;
   logic [15:0]           wr_count;
   logic                  addr_err;

   modport master (
      output i_addr, d_addr, d_wdata, d_we_n,
      output ld_valid, ld_sel, ld_addr, ld_data, ld_done,
      input  i_rdata, d_rdata, ld_ready, cpu_run, halted, halt_code, wr_count, addr_err
   );

   modport slave (
      input  i_addr, d_addr, d_wdata, d_we_n,
      input  ld_valid, ld_sel, ld_addr, ld_data, ld_done,
      output i_rdata, d_rdata, ld_ready, cpu_run, halted, halt_code, wr_count, addr_err
   );
endinterface

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the CPU's instruction and data SRAM ports, with a
// loader FSM that fills memory before releasing the CPU and a halt mailbox.
module cpu_sram_responder #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    IMEM_DEPTH = 256,
   parameter int                    DMEM_DEPTH = 256,
   parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = 16'hFFFF
) (
   input logic                clk,
   input logic                reset_n,
   cpu_sram_responder_if.slave bus
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] IMEM_LIMIT = (ADDR_WIDTH+1)'(IMEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] DMEM_LIMIT = (ADDR_WIDTH+1)'(DMEM_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

   state_t                state_q;
   logic                  ldReady_q;
   logic                  cpuRun_q;
   logic                  halted_q;
   logic [DATA_WIDTH-1:0] haltCode_q;
   logic [15:0]           wrCount_q;
   logic                  addrErr_q;

   logic [DATA_WIDTH-1:0] imem [IMEM_DEPTH];
   logic [DATA_WIDTH-1:0] dmem [DMEM_DEPTH];

   logic iInRange, dInRange, ldInRange;
   logic inRun, cpuWrite, haltWr, dmemCpuWe;
   logic ldAccept, imemLdWe, dmemLdWe, errNow;

   // The extra MSB on the limits keeps the compare correct even when a memory fills the whole address space.
   assign iInRange  = {1'b0, bus.i_addr} < IMEM_LIMIT;
   assign dInRange  = {1'b0, bus.d_addr} < DMEM_LIMIT;
   assign ldInRange = bus.ld_sel ? ({1'b0, bus.ld_addr} < DMEM_LIMIT)
                                 : ({1'b0, bus.ld_addr} < IMEM_LIMIT);

   assign inRun     = (state_q == RUN);
   assign cpuWrite  = inRun && !bus.d_we_n;
   assign haltWr    = cpuWrite && (bus.d_addr == HALT_ADDR);
   assign dmemCpuWe = cpuWrite && !haltWr && dInRange;

   assign ldAccept  = bus.ld_valid && ldReady_q;
   assign imemLdWe  = ldAccept && !bus.ld_sel && ldInRange;
   assign dmemLdWe  = ldAccept && bus.ld_sel && ldInRange;

   assign errNow = (inRun && (!iInRange || (!dInRange && !haltWr)))
                || (ldAccept && !ldInRange);

   assign bus.i_rdata   = iInRange ? imem[bus.i_addr[IAW-1:0]] : '0;
   assign bus.d_rdata   = dInRange ? dmem[bus.d_addr[DAW-1:0]] : '0;
   assign bus.ld_ready  = ldReady_q;
   assign bus.cpu_run   = cpuRun_q;
   assign bus.halted    = halted_q;
   assign bus.halt_code = haltCode_q;
   assign bus.wr_count  = wrCount_q;
   assign bus.addr_err  = addrErr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ldReady_q  <= 1'b0;
         cpuRun_q   <= 1'b0;
         halted_q   <= 1'b0;
         haltCode_q <= '0;
         wrCount_q  <= '0;
         addrErr_q  <= 1'b0;
      end else begin
         if (errNow) begin
            addrErr_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               state_q   <= LOAD;
               ldReady_q <= 1'b1;
            end
            LOAD: begin
               if (bus.ld_done) begin
                  state_q   <= RUN;
                  ldReady_q <= 1'b0;
                  cpuRun_q  <= 1'b1;
               end
            end
            RUN: begin
               if (haltWr) begin
                  state_q    <= HALT;
                  cpuRun_q   <= 1'b0;
                  halted_q   <= 1'b1;
                  haltCode_q <= bus.d_wdata;
               end else if (dmemCpuWe && (wrCount_q != 16'hFFFF)) begin
                  wrCount_q <= wrCount_q + 16'd1;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Memories carry no reset so a reload after reset can be partial.
   always_ff @(posedge clk) begin
      if (imemLdWe) begin
         imem[bus.ld_addr[IAW-1:0]] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (dmemLdWe) begin
         dmem[bus.ld_addr[DAW-1:0]] <= bus.ld_data;
      end else if (dmemCpuWe) begin
         dmem[bus.d_addr[DAW-1:0]] <= bus.d_wdata;
      end
   end
endmodule

// File: doc/cpu_sram_responder.md
# cpu_sram_responder

Memory-side responder for the pipelined CPU's two SRAM ports: an instruction port (read-only to the CPU) and a data port (read/write, active-low write enable). It holds both memories, answers CPU reads asynchronously within the cycle and commits CPU writes on the clock edge. A loader FSM fills memory from a bench or boot source before releasing the CPU. A halt mailbox address lets the CPU stop itself and report a code.

## Interface
- ADDR_WIDTH, 16, CPU address width on both ports
- DATA_WIDTH, 16, word width
- IMEM_DEPTH, 256, instruction words (power of two)
- DMEM_DEPTH, 256, data words (power of two)
- HALT_ADDR, 16'hFFFF, data-port write address treated as halt mailbox

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_addr  in  ADDR_WIDTH  instruction fetch address (CPU addr_0)
- i_rdata  out  DATA_WIDTH  instruction word (CPU inst_in)
- d_addr  in  ADDR_WIDTH  data address (CPU addr_1)
- d_wdata  in  DATA_WIDTH  write data from CPU (CPU data_out)
- d_we_n  in  1  0 = write, 1 = read
- d_rdata  out  DATA_WIDTH  read data (CPU data_in)
- ld_valid  in  1  loader word present
- ld_ready  out  1  responder accepts loader words
- ld_sel  in  1  0 = imem, 1 = dmem
- ld_addr  in  ADDR_WIDTH  loader word address
- ld_data  in  DATA_WIDTH  loader word
- ld_done  in  1  loading finished
- cpu_run  out  1  CPU may execute
- halted  out  1  halt mailbox written
- halt_code  out  DATA_WIDTH  value written to HALT_ADDR
- wr_count  out  16  accepted CPU data writes, saturating
- addr_err  out  1  sticky out-of-range flag

## Operation
- FSM states: IDLE, LOAD, RUN, HALT. Reset forces IDLE.
- IDLE → LOAD unconditionally on the next edge.
- LOAD: ld_ready=1. On ld_valid&&ld_ready, write ld_data into the memory chosen by ld_sel at ld_addr.
- ld_done in LOAD → RUN. If ld_valid and ld_done are asserted in the same cycle, the word is written and the FSM moves to RUN.
- RUN: cpu_run=1 and ld_ready=0; loader inputs are ignored. When d_we_n=0:
  - If d_addr==HALT_ADDR: latch d_wdata into halt_code and go to HALT. Nothing is stored to dmem and wr_count is not incremented.
  - Else if d_addr<DMEM_DEPTH: store dmem[d_addr]<=d_wdata and increment wr_count, saturating at 16'hFFFF.
  - Else: drop the write and set addr_err.
- HALT: cpu_run=0, halted=1. Only reset exits HALT.
- CPU writes with d_we_n=0 outside RUN are ignored.
- Reads are served in every state and are combinational:
  - i_rdata = imem[i_addr] if i_addr<IMEM_DEPTH, else 0.
  - d_rdata = dmem[d_addr] if d_addr<DMEM_DEPTH, else 0.
- addr_err is set on any edge where any of the following holds. It clears only on reset.
  - In RUN, i_addr≥IMEM_DEPTH.
  - In RUN, d_addr≥DMEM_DEPTH (except a HALT_ADDR write).
  - In LOAD, an accepted loader address is out of range; that word is dropped.
- Memory arrays are not reset. Contents survive reset_n, so a reload can be partial.

## Timing
- Reset values: state IDLE, ld_ready 0, cpu_run 0, halted 0, halt_code 0, wr_count 0, addr_err 0.
- i_rdata and d_rdata are combinational from address and array. Zero-cycle latency, valid within the same cycle.
- Read-during-write at the same d_addr: d_rdata shows the old word until the edge and the new word after it.
- ld_ready rises one edge after reset release (IDLE→LOAD).
- cpu_run rises on the edge that samples ld_done in LOAD. It falls on the edge that accepts the HALT_ADDR write; halted rises on that same edge.
- Loader throughput: one word per cycle.
- reset_n asserted mid-operation takes effect immediately. A write on that cycle is not guaranteed to commit.

## Test plan
- Load imem[0..3]=16'h2010,16'h1011,16'h3012,16'h7001 and dmem[16]=5, dmem[17]=7; pulse ld_done -> cpu_run=1 the next cycle; i_addr=2 gives i_rdata=16'h3012 combinationally.
- RUN, d_we_n=0, d_addr=18, d_wdata=16'h000C -> after the edge d_rdata=16'h000C at addr 18 and wr_count=1; before the edge d_rdata is the old value.
- RUN, write d_addr=16'hFFFF, d_wdata=16'hBEEF -> halted=1, halt_code=16'hBEEF, cpu_run=0, wr_count unchanged; a later write at addr 3 is ignored.
- RUN, i_addr=16'h0100 (≥IMEM_DEPTH) -> i_rdata=0 and addr_err=1 after the edge, held until reset.
- In LOAD, ld_valid=1 and ld_done=1 in the same cycle with dmem addr 5, data 16'hA5A5 -> word stored and RUN entered. Then assert reset_n low -> all outputs return to reset values, and dmem[5] still reads 16'hA5A5 on the next load.
